// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state and owner encodings shared by mem_port_arbiter and mem_arb_pick.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant decision between IF and data; MEM_ARB_STARVE_GUARD_EN adds the IF starvation guard.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_req_valid,
  input  logic d_req_valid,
  output logic pick
);
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] cnt_q, cnt_d;
  logic force_if;
  // counts data grants that made a waiting fetch lose
  always_comb begin
    force_if = if_req_valid && cnt_q == 3'(STARVE_MAX);
    pick = (d_req_valid && !force_if) ? OWN_D : OWN_IF;
    cnt_d = cnt_q;
    if (idle && if_req_valid) cnt_d = (pick == OWN_D) ? cnt_q + 3'd1 : 3'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused;
  assign unused = ^{clk, reset, idle, if_req_valid};
  assign pick = d_req_valid ? OWN_D : OWN_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and data requesters, one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX contested data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_be,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                owner
);
  state_e state_q, state_d;
  logic owner_q, owner_d, req_valid_q, req_valid_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_data_q, if_data_d, d_data_q, d_data_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic if_rsp_q, if_rsp_d, d_rsp_q, d_rsp_d;
  logic pick, idle, if_acc, d_acc;
  assign idle = state_q == IDLE;
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk(clk), .reset(reset), .idle(idle),
    .if_req_valid(if_req_valid), .d_req_valid(d_req_valid), .pick(pick)
  );
  always_comb begin
    if_req_ready = idle && !reset && pick == OWN_IF;
    d_req_ready = idle && !reset && pick == OWN_D;
    if_acc = if_req_valid && if_req_ready;
    d_acc = d_req_valid && d_req_ready;
    state_d = state_q;
    owner_d = owner_q;
    req_valid_d = 1'b0;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    if_rsp_d = 1'b0;
    d_rsp_d = 1'b0;
    if_data_d = if_data_q;
    d_data_d = d_data_q;
    case (state_q)
      IDLE: if (if_acc || d_acc) begin
        state_d = ISSUE;
        owner_d = d_acc ? OWN_D : OWN_IF;
        req_valid_d = 1'b1;
        we_d = d_acc && d_req_we;
        addr_d = d_acc ? d_req_addr : if_req_addr;
        wdata_d = d_acc ? d_req_wdata : '0;
        be_d = d_acc ? d_req_be : '1;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (mem_rsp_valid) begin
        state_d = IDLE;
        if_rsp_d = owner_q == OWN_IF;
        d_rsp_d = owner_q == OWN_D;
        if_data_d = (owner_q == OWN_IF) ? mem_rsp_data : if_data_q;
        // stores are acknowledged with zero data
        d_data_d = (owner_q == OWN_D) ? (we_q ? '0 : mem_rsp_data) : d_data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      req_valid_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      if_rsp_q <= 1'b0;
      d_rsp_q <= 1'b0;
      if_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_valid_q <= req_valid_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      if_rsp_q <= if_rsp_d;
      d_rsp_q <= d_rsp_d;
      if_data_q <= if_data_d;
      d_data_q <= d_data_d;
    end
  end
  assign owner = owner_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_we = we_q;
  assign mem_req_addr = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be = be_q;
  assign if_rsp_valid = if_rsp_q;
  assign if_rsp_data = if_data_q;
  assign d_rsp_valid = d_rsp_q;
  assign d_rsp_data = d_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic against a transaction-level model of the shared port.
module tb_mem_port_arbiter;
  localparam int SM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr = '0, if_rsp_data;
  logic d_req_valid = 1'b0, d_req_we = 1'b0, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0, d_rsp_data;
  logic [3:0] d_req_be = '0, mem_req_be;
  logic mem_req_valid, mem_req_we, mem_rsp_valid = 1'b0, owner;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .owner(owner)
  );

  int n_chk = 0, n_pass = 0;
  bit if_pend, d_pend, d_we_s;
  logic [31:0] if_addr_s, d_addr_s, d_wdata_s, next_if = 32'h1000;
  logic [3:0] d_be_s;
  bit open, own_m, issue_now, rsp_now, t_we;
  logic [31:0] t_addr, t_wdata, exp_data, mem_data;
  logic [3:0] t_be;
  int mem_cnt, cnt_m, p_if, p_d, p_we, lat_lo = 1, lat_hi = 1, n_if_rsp;
  bit glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive_reqs();
    if (!if_pend && $urandom_range(99) < p_if) begin
      if_pend = 1'b1;
      if_addr_s = next_if;
      next_if += 4;
    end
    if (!d_pend && $urandom_range(99) < p_d) begin
      d_pend = 1'b1;
      d_we_s = $urandom_range(99) < p_we;
      d_addr_s = $urandom & 32'hFFFF_FFFC;
      d_wdata_s = $urandom;
      d_be_s = 4'($urandom);
    end
    if_req_valid = if_pend;
    if_req_addr = if_addr_s;
    d_req_valid = d_pend;
    d_req_we = d_we_s;
    d_req_addr = d_addr_s;
    d_req_wdata = d_wdata_s;
    d_req_be = d_be_s;
  endtask

  // one clock: check DUT against the model at negedge, advance the model, drive next inputs
  task automatic cycle();
    bit free, pick, e_if, e_d;
    @(negedge clk);
    free = !open || rsp_now;
    pick = d_req_valid && !(GUARD && if_req_valid && cnt_m == SM);
    e_if = !reset && free && !pick;
    e_d = !reset && free && pick;
    check("if_req_ready", 32'(if_req_ready), 32'(e_if));
    check("d_req_ready", 32'(d_req_ready), 32'(e_d));
    check("mem_req_valid", 32'(mem_req_valid), 32'(issue_now));
    if (issue_now) begin
      check("mem_req_addr", mem_req_addr, t_addr);
      check("mem_req_we", 32'(mem_req_we), 32'(t_we));
      if (own_m) check("mem_req_wdata", mem_req_wdata, t_wdata);
      if (own_m) check("mem_req_be", 32'(mem_req_be), 32'(t_be));
    end
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(rsp_now && !own_m));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(rsp_now && own_m));
    if (open) check("owner", 32'(owner), 32'(own_m));
    if (rsp_now) begin
      check(own_m ? "d_rsp_data" : "if_rsp_data", own_m ? d_rsp_data : if_rsp_data, exp_data);
      if (!own_m) n_if_rsp++;
      open = 1'b0;
    end
    rsp_now = mem_rsp_valid && open && !issue_now;
    if (rsp_now) exp_data = t_we ? 32'h0 : mem_rsp_data;
    if (issue_now) begin
      mem_cnt = int'($urandom_range(lat_hi, lat_lo));
      mem_data = t_we ? 32'hFFFF_FFFF : t_addr + 32'd3;
    end
    issue_now = 1'b0;
    if ((if_req_valid && e_if) || (d_req_valid && e_d)) begin
      own_m = d_req_valid && e_d;
      open = 1'b1;
      issue_now = 1'b1;
      t_we = own_m && d_req_we;
      t_addr = own_m ? d_req_addr : if_req_addr;
      t_wdata = d_req_wdata;
      t_be = d_req_be;
      glog.push_back(own_m);
      if (own_m) begin
        d_pend = 1'b0;
        if (if_req_valid) cnt_m++;
      end else begin
        if_pend = 1'b0;
        cnt_m = 0;
      end
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = mem_data;
      end
    end
    drive_reqs();
  endtask

  task automatic do_reset(input bit keep_mem);
    p_if = 0;
    p_d = 0;
    if_pend = 1'b0;
    d_pend = 1'b0;
    reset = 1'b1;
    drive_reqs();
    open = 1'b0;
    issue_now = 1'b0;
    rsp_now = 1'b0;
    cnt_m = 0;
    if (!keep_mem) begin
      mem_cnt = 0;
      mem_rsp_valid = 1'b0;
    end
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_mem_req_addr", mem_req_addr, 32'h0);
    check("rst_if_rsp_data", if_rsp_data, 32'h0);
    check("rst_d_rsp_data", d_rsp_data, 32'h0);
    @(posedge clk);
    #1;
    do_reset(1'b0);
    // single fetch, memory latency 2
    lat_lo = 2; lat_hi = 2;
    if_pend = 1'b1; if_addr_s = 32'h10;
    drive_reqs();
    for (int i = 0; i < 8; i++) cycle();
    // contested load and fetch
    do_reset(1'b0);
    glog.delete();
    lat_lo = 1; lat_hi = 3;
    d_pend = 1'b1; d_we_s = 1'b0; d_addr_s = 32'h100; d_wdata_s = '0; d_be_s = 4'hF;
    if_pend = 1'b1; if_addr_s = 32'h104;
    drive_reqs();
    for (int i = 0; i < 16; i++) cycle();
    check("t2_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t2_first_data", 32'(glog[0]), 32'd1);
      check("t2_second_if", 32'(glog[1]), 32'd0);
    end
    // store
    d_pend = 1'b1; d_we_s = 1'b1; d_addr_s = 32'h200; d_wdata_s = 32'hDEADBEEF; d_be_s = 4'b0011;
    drive_reqs();
    for (int i = 0; i < 8; i++) cycle();
    // reset while waiting; the late response must vanish
    lat_lo = 5; lat_hi = 5;
    if_pend = 1'b1; if_addr_s = 32'h300;
    drive_reqs();
    for (int i = 0; i < 3; i++) cycle();
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) cycle();
    // both sides always requesting
    do_reset(1'b0);
    glog.delete();
    lat_lo = 1; lat_hi = 2;
    p_if = 100; p_d = 100; p_we = 30;
    for (int i = 0; i < 600 && glog.size() < 15; i++) cycle();
    check("t5_grant_count", 32'(glog.size() >= 15), 32'd1);
    for (int i = 0; i < 15 && i < glog.size(); i++)
      check("t5_grant_pattern", 32'(glog[i]), (GUARD && i % 5 == 4) ? 32'd0 : 32'd1);
    // 200 back-to-back fetches, latency 1..5
    do_reset(1'b0);
    lat_lo = 1; lat_hi = 5;
    p_if = 100;
    n_if_rsp = 0;
    for (int i = 0; i < 3000 && n_if_rsp < 200; i++) cycle();
    check("t6_fetch_count", 32'(n_if_rsp >= 200), 32'd1);
    // mixed random traffic
    p_if = 50; p_d = 50; p_we = 40;
    for (int i = 0; i < 400; i++) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
